// File: rtl/sequence_generator.sv
// Serial 01[0*]1 frame transmitter with frame counter and active-low 7-segment readout.
// Optional build macro SEQGEN_RANDOM_ZEROS_EN replaces the latched zero count with a 4-bit LFSR.
module sequence_generator #(
   parameter int ZW  = 4,
   parameter int FW  = 7,
   parameter int GAP = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ena,
   input  logic          start,
   input  logic          abort,
   input  logic [ZW-1:0] num_zeros,
   input  logic [FW-1:0] num_frames,
   output logic          sig_out,
   output logic          busy,
   output logic          done,
   output logic          frame_end,
   output logic [FW-1:0] frames_sent,
   output logic [6:0]    disp0,
   output logic [6:0]    disp1
);

   localparam int GW = (GAP > 1) ? $clog2(GAP + 1) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEAD0,
      S_LEAD1,
      S_ZEROS,
      S_TAIL1,
      S_GAP
   } state_t;

   state_t        state_q;
   logic          sig_q, busy_q, done_q, fe_q;
   logic [FW-1:0] frames_q, frames_d, nf_lat_q;
   logic [ZW-1:0] zeros_lat_q, zcnt_q, k_d;
   logic [GW-1:0] gcnt_q;
   logic [6:0]    disp0_q, disp1_q;
   logic [31:0]   fs_mod_d;
   logic [3:0]    ones_d, tens_d;

`ifdef SEQGEN_RANDOM_ZEROS_EN
   logic [3:0] lfsr_q, lfsr_d;
   always_comb begin
      lfsr_d = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
      k_d    = ZW'(lfsr_q);
   end
`else
   always_comb k_d = zeros_lat_q;
`endif

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b1000000;
         4'd1:    seg7 = 7'b1111001;
         4'd2:    seg7 = 7'b0100100;
         4'd3:    seg7 = 7'b0110000;
         4'd4:    seg7 = 7'b0011001;
         4'd5:    seg7 = 7'b0010010;
         4'd6:    seg7 = 7'b0000010;
         4'd7:    seg7 = 7'b1111000;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0011000;
         default: seg7 = 7'b1111111;
      endcase
   endfunction

   // Saturating frame count, plus the decimal split of its value mod 100.
   always_comb begin
      frames_d = (frames_q == '1) ? frames_q : frames_q + FW'(1);
      fs_mod_d = 32'(frames_q) % 32'd100;
      ones_d   = 4'(fs_mod_d % 32'd10);
      tens_d   = 4'(fs_mod_d / 32'd10);
   end

   // NOTE: all state here is registered with non-blocking assignments so every
   // branch reads the pre-edge values of the other registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         sig_q       <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         fe_q        <= 1'b0;
         frames_q    <= '0;
         nf_lat_q    <= '0;
         zeros_lat_q <= '0;
         zcnt_q      <= '0;
         gcnt_q      <= '0;
         disp0_q     <= 7'b1000000;
         disp1_q     <= 7'b1000000;
`ifdef SEQGEN_RANDOM_ZEROS_EN
         lfsr_q      <= 4'b0001;
`endif
      end else begin
         done_q  <= 1'b0;
         fe_q    <= 1'b0;
         disp0_q <= seg7(ones_d);
         disp1_q <= seg7(tens_d);
         if (abort && state_q != S_IDLE) begin
            state_q <= S_IDLE;
            sig_q   <= 1'b1;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (start && !abort) begin
                     nf_lat_q    <= num_frames;
                     zeros_lat_q <= num_zeros;
                     frames_q    <= '0;
                     if (num_frames == '0) begin
                        done_q <= 1'b1;
                     end else begin
                        busy_q  <= 1'b1;
                        state_q <= S_LEAD0;
                        sig_q   <= 1'b0;
                     end
                  end
               end
               S_LEAD0: begin
                  if (ena) begin
                     state_q <= S_LEAD1;
                     sig_q   <= 1'b1;
                  end
               end
               S_LEAD1: begin
                  if (ena) begin
                     if (k_d == '0) begin
                        state_q <= S_TAIL1;
                        sig_q   <= 1'b1;
                     end else begin
                        state_q <= S_ZEROS;
                        sig_q   <= 1'b0;
                        zcnt_q  <= k_d;
                     end
                  end
               end
               S_ZEROS: begin
                  if (ena) begin
                     if (zcnt_q == ZW'(1)) begin
                        state_q <= S_TAIL1;
                        sig_q   <= 1'b1;
                     end else begin
                        zcnt_q <= zcnt_q - ZW'(1);
                     end
                  end
               end
               S_TAIL1: begin
                  if (ena) begin
                     frames_q <= frames_d;
                     fe_q     <= 1'b1;
`ifdef SEQGEN_RANDOM_ZEROS_EN
                     lfsr_q   <= lfsr_d;
`endif
                     if (frames_d == nf_lat_q) begin
                        state_q <= S_IDLE;
                        sig_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                     end else if (GAP == 0) begin
                        state_q <= S_LEAD0;
                        sig_q   <= 1'b0;
                     end else begin
                        state_q <= S_GAP;
                        sig_q   <= 1'b1;
                        gcnt_q  <= GW'(GAP);
                     end
                  end
               end
               S_GAP: begin
                  if (ena) begin
                     if (gcnt_q == GW'(1)) begin
                        state_q <= S_LEAD0;
                        sig_q   <= 1'b0;
                     end else begin
                        gcnt_q <= gcnt_q - GW'(1);
                     end
                  end
               end
               default: begin
                  state_q <= S_IDLE;
                  sig_q   <= 1'b1;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign sig_out     = sig_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign frame_end   = fe_q;
   assign frames_sent = frames_q;
   assign disp0       = disp0_q;
   assign disp1       = disp1_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Bench for sequence_generator: a bit-queue model of the burst is compared every cycle,
// with directed scenarios pinned by literal expectations, then randomized traffic.
module tb_sequence_generator;

   localparam int ZW  = 4;
   localparam int FW  = 7;
   localparam int GAP = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          ena = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [ZW-1:0] num_zeros = '0;
   logic [FW-1:0] num_frames = '0;
   logic          sig_out, busy, done, frame_end;
   logic [FW-1:0] frames_sent;
   logic [6:0]    disp0, disp1;

   sequence_generator #(.ZW(ZW), .FW(FW), .GAP(GAP)) dut (
      .clk(clk), .rst(rst), .ena(ena), .start(start), .abort(abort),
      .num_zeros(num_zeros), .num_frames(num_frames),
      .sig_out(sig_out), .busy(busy), .done(done), .frame_end(frame_end),
      .frames_sent(frames_sent), .disp0(disp0), .disp1(disp1)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_mis = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: the burst is a queue of {tail, bit} entries; each ena edge retires one.
   logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000};
   logic [1:0] mq[$];
   int         m_frames = 0, m_nf = 0, m_k = 0;
   logic       m_busy = 1'b0, m_sig = 1'b1, m_done = 1'b0, m_fe = 1'b0;
   logic [6:0] m_d0 = 7'b1000000, m_d1 = 7'b1000000;

   task automatic push_frame();
      mq.push_back(2'b00);
      mq.push_back(2'b01);
      for (int z = 0; z < m_k; z++) mq.push_back(2'b00);
      mq.push_back(2'b11);
   endtask

   always @(posedge clk) begin
      logic [1:0] e;
      if (rst) begin
         mq.delete();
         m_busy = 1'b0; m_sig = 1'b1; m_done = 1'b0; m_fe = 1'b0; m_frames = 0;
         m_d0 = 7'b1000000; m_d1 = 7'b1000000;
      end else begin
         m_d0 = seg_tab[(m_frames % 100) % 10];
         m_d1 = seg_tab[(m_frames % 100) / 10];
         m_done = 1'b0;
         m_fe   = 1'b0;
         if (m_busy) begin
            if (abort) begin
               m_busy = 1'b0;
               mq.delete();
            end else if (ena) begin
               e = mq.pop_front();
               if (e[1]) begin
                  m_fe = 1'b1;
                  if (m_frames < (1 << FW) - 1) m_frames++;
                  if (m_frames == m_nf) begin
                     m_busy = 1'b0;
                     m_done = 1'b1;
                     mq.delete();
                  end else begin
                     for (int g = 0; g < GAP; g++) mq.push_back(2'b01);
                     push_frame();
                  end
               end
            end
         end else if (start && !abort) begin
            m_nf     = int'(num_frames);
            m_k      = int'(num_zeros);
            m_frames = 0;
            if (m_nf == 0) m_done = 1'b1;
            else begin
               m_busy = 1'b1;
               push_frame();
            end
         end
         m_sig = m_busy ? mq[0][0] : 1'b1;
      end
   end

   always @(negedge clk) begin
      check("sig_out", sig_out, m_sig);
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("frame_end", frame_end, m_fe);
      check("frames_sent", frames_sent, m_frames);
      check("disp0", disp0, m_d0);
      check("disp1", disp1, m_d1);
   end

   int e1[6]  = '{0, 1, 0, 0, 1, 1};
   int e2[13] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1};
   int e4[8]  = '{0, 0, 1, 1, 0, 0, 1, 1};

   initial begin
      int fe_cnt, dn_cnt, got;
      repeat (2) @(negedge clk);
      check("rst_sig", sig_out, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_frames", frames_sent, 0);
      check("rst_disp0", disp0, 7'b1000000);
      check("rst_disp1", disp1, 7'b1000000);
      rst = 1'b0;

      // Single frame, k=2
      ena = 1'b1; num_zeros = 4'd2; num_frames = 7'd1; start = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         start = 1'b0;
         check($sformatf("t1_sig[%0d]", i), sig_out, e1[i]);
      end
      check("t1_done", done, 1);
      check("t1_fe", frame_end, 1);
      check("t1_frames", frames_sent, 1);
      check("t1_busy", busy, 0);
      @(negedge clk);
      check("t1_disp0", disp0, 7'b1111001);
      check("t1_done_clr", done, 0);

      // Three frames, k=0
      num_zeros = 4'd0; num_frames = 7'd3; start = 1'b1;
      fe_cnt = 0; dn_cnt = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         start = 1'b0;
         check($sformatf("t2_sig[%0d]", i), sig_out, (i < 13) ? e2[i] : 1);
         if (frame_end === 1'b1) fe_cnt++;
         if (done === 1'b1) begin
            dn_cnt++;
            check("t2_busy_fall", busy, 0);
            check("t2_done_cycle", i, 13);
         end
      end
      check("t2_fe_count", fe_cnt, 3);
      check("t2_done_count", dn_cnt, 1);

      // Zero-frame burst
      num_frames = 7'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("t3_done", done, 1);
      check("t3_busy", busy, 0);
      check("t3_sig", sig_out, 1);
      check("t3_frames", frames_sent, 0);
      @(negedge clk);
      check("t3_done_clr", done, 0);

      // ena every other cycle, k=1, with a start pulse while busy
      num_zeros = 4'd1; num_frames = 7'd1; ena = 1'b1; start = 1'b1;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         if (i < 8) check($sformatf("t4_sig[%0d]", i), sig_out, e4[i]);
         else begin
            check("t4_done", done, 1);
            check("t4_sig_idle", sig_out, 1);
         end
         ena   = (i % 2 == 1);
         start = (i == 3);
      end
      ena = 1'b1; start = 1'b0;

      // Abort inside ZEROS of frame 2 of 5
      num_zeros = 4'd3; num_frames = 7'd5; start = 1'b1;
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         start = 1'b0;
      end
      check("t5_in_zeros", sig_out, 0);
      check("t5_busy_pre", busy, 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("t5_abort_sig", sig_out, 1);
      check("t5_abort_busy", busy, 0);
      check("t5_abort_done", done, 0);
      check("t5_abort_frames", frames_sent, 1);

      // Synchronous reset mid-burst
      start = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         start = 1'b0;
      end
      check("t5_disp0_pre", disp0, 7'b1111001);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t5_rst_sig", sig_out, 1);
      check("t5_rst_busy", busy, 0);
      check("t5_rst_fe", frame_end, 0);
      check("t5_rst_frames", frames_sent, 0);
      check("t5_rst_disp0", disp0, 7'b1000000);

      // Twelve frames: two-digit display
      num_zeros = 4'd1; num_frames = 7'd12; start = 1'b1;
      got = 0;
      for (int i = 0; i < 200 && got == 0; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (done === 1'b1) got = 1;
      end
      check("t6_done_seen", got, 1);
      check("t6_frames", frames_sent, 12);
      @(negedge clk);
      check("t6_disp1", disp1, 7'b1111001);
      check("t6_disp0", disp0, 7'b0100100);

      // Randomized traffic against the model
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         ena        = ($urandom_range(0, 3) != 0);
         start      = ($urandom_range(0, 7) == 0);
         abort      = ($urandom_range(0, 63) == 0);
         rst        = ($urandom_range(0, 255) == 0);
         num_zeros  = ZW'($urandom_range(0, 15));
         num_frames = FW'($urandom_range(0, 5));
      end
      rst = 1'b0; start = 1'b0; abort = 1'b0;
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_mis);
      $finish;
   end

endmodule
